// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped peripherals (UART TX now,
// keyboard/LED blocks later): default register addresses, status bit
// positions and the transmitter state encoding.
package hack_io_pkg;

  localparam logic [14:0] DATA_ADDR_DEF = 15'h6001;
  localparam logic [14:0] STAT_ADDR_DEF = 15'h6002;

  // Status register bit positions
  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/hack_uart_tx_if.sv
// Hack CPU data-bus slice seen by a memory-mapped responder.
//   in      : write data (CPU outM)
//   load    : write strobe (CPU writeM)
//   address : CPU addressM
//   out     : read data back toward Mout
interface hack_bus_if;
  logic [15:0] in;
  logic        load;
  logic [14:0] address;
  logic [15:0] out;

  modport master (output in, load, address, input out);
  modport slave  (input in, load, address, output out);
endinterface

// File: rtl/hack_uart_tx_sync_fifo.sv
// Single-clock FIFO, parameterized width/depth (depth a power of two).
//   push/din : write side; a push while full is accepted only if a pop
//              happens in the same cycle
//   pop/dout : read side; dout shows the head entry, pop is ignored if empty
//   full/empty/count : occupancy, count is one bit wider than the pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot, so a push against a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hack_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the Hack data bus.
//   clk_in  : system clock
//   reset   : synchronous, active-high
//   bus     : CPU bus responder (write DATA_ADDR pushes a byte, write
//             STAT_ADDR clears overflow, read STAT_ADDR returns
//             {13'b0, overflow, busy, full}, other reads return 0)
//   tx      : registered serial output, idle high
module hack_uart_tx
  import hack_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [14:0] DATA_ADDR    = DATA_ADDR_DEF,
  parameter logic [14:0] STAT_ADDR    = STAT_ADDR_DEF,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  hack_bus_if.slave  bus,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;

  logic           wr_data, wr_stat, tick;
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           busy, stat_full;
  logic [15:0]    stat;

  assign wr_data = bus.load && (bus.address == DATA_ADDR);
  assign wr_stat = bus.load && (bus.address == STAT_ADDR);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst   (reset),
    .push  (wr_data),
    .din   (bus.in[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tick      = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign stat_full = (fifo_count == CW'(FIFO_DEPTH));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        // Decision uses the registered FIFO state, so a byte written this
        // cycle is popped no earlier than the next one.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the state one cycle later, keeping the pin glitch-free.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    ovf_d = ovf_q;
    if (wr_stat)                             ovf_d = 1'b0;
    else if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx = tx_q;

  always_comb begin
    stat          = '0;
    stat[ST_FULL] = stat_full;
    stat[ST_BUSY] = busy;
    stat[ST_OVF]  = ovf_q;
    bus.out       = (bus.address == STAT_ADDR) ? stat : 16'h0000;
  end

endmodule

// File: tb/tb_hack_uart_tx.sv
// Bench for hack_uart_tx with CLKS_PER_BIT=4: a frame-timeline model plus a
// line decoder, checked every cycle, and directed scenarios with literal
// expectations.
module tb_hack_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;
  localparam logic [14:0] DA = 15'h6001;
  localparam logic [14:0] SA = 15'h6002;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  always #5 clk = ~clk;

  hack_bus_if bus();

  hack_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_ADDR(DA), .STAT_ADDR(SA),
                 .FIFO_DEPTH(DEPTH)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus),
    .tx     (tx)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of waiting bytes + position in frame
  logic [7:0] mq[$];
  int         fpos = -1;      // cycles since the current frame was popped
  logic [7:0] cur = 8'h00;
  logic       m_tx = 1'b1;
  logic       m_ovf = 1'b0;

  function automatic logic bitval(input int pos, input logic [7:0] b);
    int idx;
    if (pos < 0) return 1'b1;
    idx = pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      fpos  = -1;
      m_tx  = 1'b1;
      m_ovf = 1'b0;
    end else begin
      int old;
      bit popped;
      old    = mq.size();
      popped = 1'b0;
      m_tx   = bitval(fpos, cur);
      if (fpos >= 0) begin
        fpos++;
        if (fpos == FRAME) begin
          if (old > 0) begin cur = mq.pop_front(); fpos = 0; popped = 1'b1; end
          else fpos = -1;
        end
      end else if (old > 0) begin
        cur = mq.pop_front(); fpos = 0; popped = 1'b1;
      end
      if (bus.load && bus.address == DA) begin
        if (old < DEPTH || popped) mq.push_back(bus.in[7:0]);
        else m_ovf = 1'b1;
      end else if (bus.load && bus.address == SA) begin
        m_ovf = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare + serial decoder
  int         cyc = 0;
  bit         rx_act = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_b = 8'h00;
  logic [7:0] rxq[$];
  int         starts[$];

  always @(negedge clk) begin
    logic [15:0] eo;
    logic m_busy, m_full;
    cyc++;
    m_busy = (fpos >= 0) || (mq.size() > 0);
    m_full = (mq.size() == DEPTH);
    eo = (bus.address == SA) ? {13'b0, m_ovf, m_busy, m_full} : 16'h0000;
    chk("tx_vs_model", {15'b0, tx}, {15'b0, m_tx});
    chk("out_vs_model", bus.out, eo);

    if (reset) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx == 1'b0) begin rx_act = 1'b1; rx_t = 0; starts.push_back(cyc); end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB/2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
        rx_b[rx_t/CPB-1] = tx;
      if (rx_t == 9*CPB + CPB/2) begin
        chk("stop_bit", {15'b0, tx}, 16'h0001);
        rxq.push_back(rx_b);
        rx_act = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (start/end just after a posedge)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.address = a; bus.in = d; bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0; bus.address = SA;
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && fpos < 0 && !rx_act && tx === 1'b1) begin done = 1'b1; break; end
      tick(1);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
    tick(3);
  endtask

  task automatic clr();
    rxq.delete(); starts.delete();
  endtask

  initial begin
    reset = 1'b1; bus.load = 1'b0; bus.address = SA; bus.in = 16'h0000;
    tick(2);
    chk("reset_tx", {15'b0, tx}, 16'h0001);
    chk("reset_stat", bus.out, 16'h0000);
    reset = 1'b0;
    tick(2);

    // single byte 0x55 (high byte ignored)
    clr();
    wr(DA, 16'hAB55);
    chk("busy_after_write", bus.out, 16'h0002);
    tick(1);
    chk("tx_high_edge1", {15'b0, tx}, 16'h0001);
    tick(1);
    chk("tx_start_edge2", {15'b0, tx}, 16'h0000);
    drain();
    chk("single_count", 16'(rxq.size()), 16'd1);
    if (rxq.size() >= 1) chk("single_byte", {8'h00, rxq[0]}, 16'h0055);
    chk("single_idle_stat", bus.out, 16'h0000);

    // back-to-back frames
    clr();
    wr(DA, 16'h0001); wr(DA, 16'h0002); wr(DA, 16'h0003);
    drain();
    chk("b2b_count", 16'(rxq.size()), 16'd3);
    if (rxq.size() == 3) begin
      chk("b2b_b0", {8'h00, rxq[0]}, 16'h0001);
      chk("b2b_b1", {8'h00, rxq[1]}, 16'h0002);
      chk("b2b_b2", {8'h00, rxq[2]}, 16'h0003);
    end
    if (starts.size() == 3) begin
      chk("b2b_gap01", 16'(starts[1] - starts[0]), 16'd40);
      chk("b2b_gap12", 16'(starts[2] - starts[1]), 16'd40);
    end

    // overflow
    clr();
    for (int i = 0; i < 6; i++) wr(DA, 16'(16'h0010 + i));
    chk("ovf_status", bus.out, 16'h0007);
    bus.address = DA; #1;
    chk("read_data_addr", bus.out, 16'h0000);
    bus.address = SA; #1;
    wr(SA, 16'hFFFF);
    chk("ovf_cleared", bus.out, 16'h0003);
    drain();
    chk("ovf_frames", 16'(rxq.size()), 16'd5);
    if (rxq.size() == 5) begin
      chk("ovf_first", {8'h00, rxq[0]}, 16'h0010);
      chk("ovf_last", {8'h00, rxq[4]}, 16'h0014);
    end

    // push exactly on the STOP->START pop edge while full
    clr();
    for (int i = 0; i < 5; i++) wr(DA, 16'(16'h0020 + i));
    tick(36);
    wr(DA, 16'h0025);
    chk("pushpop_stat", bus.out, 16'h0003);
    drain();
    chk("pushpop_count", 16'(rxq.size()), 16'd6);
    if (rxq.size() == 6)
      for (int i = 0; i < 6; i++) chk("pushpop_order", {8'h00, rxq[i]}, 16'(16'h0020 + i));

    // reset mid-frame
    clr();
    wr(DA, 16'h005A);
    tick(10);
    reset = 1'b1;
    tick(1);
    chk("reset_mid_tx", {15'b0, tx}, 16'h0001);
    chk("reset_mid_stat", bus.out, 16'h0000);
    reset = 1'b0;
    tick(50);
    chk("reset_mid_no_frame", 16'(rxq.size()), 16'd0);

    // decode: non-matching addresses
    clr();
    wr(15'h6000, 16'h00AA);
    wr(15'h1002, 16'h00AA);
    tick(50);
    chk("decode_no_frame", 16'(rxq.size()), 16'd0);
    chk("decode_stat", bus.out, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
